ws2812_frame_sched: RTL and testbench
=====================================

# ws2812_frame_sched

Frame-level scheduler for the WS2812 LED strip chain. It arbitrates between two frame sources, each presenting a packed N_PIX-pixel frame. It latches the winning frame and feeds it one 24-bit word at a time to the bit-serial WS2812 driver through a valid/ready handshake. It then enforces the strip latch/reset gap before the next frame is accepted.

## Interface
- N_PIX, 60, pixels per frame
- PIX_W, 24, bits per pixel word (GRB as packed by sources; driver owns bit order)
- RESET_CYC, 15000, line-low reset gap in clk cycles (300 us at 50 MHz); must be ≥1
- clk  in  1  system clock; one clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  2  per-source frame request; held high until matching gnt
- frame0  in  N_PIX*PIX_W  source 0 frame; pixel p at bits [PIX_W*p +: PIX_W]
- frame1  in  N_PIX*PIX_W  source 1 frame, same packing
- gnt  out  2  one-cycle pulse: frame of that source latched
- done  out  2  one-cycle pulse: granted source's frame fully shown, reset gap complete
- busy  out  1  high in every state except IDLE
- tx_en  out  1  driver enable; high in SEND and DRAIN only
- pix_valid  out  1  pix_data holds a valid pixel word
- pix_data  out  PIX_W  current pixel word
- pix_ready  in  1  driver accepts word; transfer when pix_valid && pix_ready
- drv_busy  in  1  driver still shifting bits

## Operation
- States: GAP, IDLE, SEND, DRAIN. Reset enters GAP with cnt=0, so the first frame is preceded by a full reset gap.
- GAP: cnt increments each cycle. At cnt==RESET_CYC-1, go to IDLE. done[owner] pulses that cycle unless the gap followed reset.
- IDLE: on any req bit high, select the winner round-robin. Tie goes to the source not served last; after reset source 0 wins a tie. Latch its frame into the internal buffer, set owner, pulse gnt[owner], and go to SEND with idx=0, pix_data=pixel 0, pix_valid=1.
- SEND: on each transfer, if idx==N_PIX-1, drop pix_valid and go to DRAIN. Otherwise idx+1 and pix_data=next pixel. pix_data is stable while pix_valid && !pix_ready.
- DRAIN: wait for drv_busy==0, then go to GAP with cnt=0.
- Requests are sampled only in IDLE; requests arriving in SEND/DRAIN/GAP wait. A req dropped before gnt yields no grant.
- Sources may change their frame the cycle after gnt; the buffer is independent.
- rst at any point: the next cycle is in GAP with cnt=0; any in-progress frame is abandoned and no done pulse is issued for it.
- Widths: idx is $clog2(N_PIX) bits; cnt is $clog2(RESET_CYC) bits. No overflow, because both counters stop at their terminal value.

## Timing
- Reset values: gnt=0, done=0, busy=1 (GAP), tx_en=0, pix_valid=0, pix_data=0, owner=0, last-served=1.
- req seen high in IDLE at edge k. At k+1: gnt pulse, pix_valid=1, tx_en=1, busy=1.
- With pix_ready held high, one pixel transfers per cycle: N_PIX transfers in N_PIX cycles, and pix_valid falls the cycle after the last transfer.
- DRAIN→GAP takes one cycle after drv_busy is seen low. GAP lasts exactly RESET_CYC cycles. done pulses on the last GAP cycle, and IDLE follows on the next edge.
- Minimum frame period with an always-ready, never-busy driver: 1 (IDLE) + N_PIX + 1 (DRAIN) + RESET_CYC cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package ws2812_pkg holds PIX_W=24, default N_PIX=60, default RESET_CYC=15000, and the state enum {GAP, IDLE, SEND, DRAIN}.
- Sub-module ws2812_rr_arb: a 2-way round-robin arbiter with its last-served register, taking req and an update strobe and returning a one-hot winner. Everything else lives in ws2812_frame_sched.
- The frame buffer is a flat N_PIX*PIX_W register. pix_data is muxed by idx and registered.

## Test plan
- Post-reset: req=2'b01 held from cycle 0 → no gnt before RESET_CYC cycles. Then gnt=01, and 60 words equal to frame0 pixels 0..59 appear in order; done=01 exactly RESET_CYC cycles after DRAIN exit.
- Simultaneous req=2'b11 across three frames → grants alternate 01, 10, 01. After reset, the first tie goes to source 0.
- pix_ready toggled 1-0-1 with random stalls → pix_data is stable during stalls, there are no duplicated or skipped pixels, and exactly 60 transfers occur.
- drv_busy held high 100 cycles after the last transfer → the state stays in DRAIN and tx_en=1. The gap count starts only after drv_busy falls.
- frame0 changed the cycle after gnt → the transmitted words match the frame latched at grant time.
- rst pulsed mid-SEND at pixel 30 → next cycle tx_en=0, pix_valid=0, no done is issued, and a full RESET_CYC gap precedes the next grant.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared constants and state encoding for the WS2812 frame scheduler.
package ws2812_pkg;

  localparam int PIX_W         = 24;
  localparam int N_PIX_DEF     = 60;
  localparam int RESET_CYC_DEF = 15000;

  typedef enum logic [1:0] {
    GAP   = 2'd0,
    IDLE  = 2'd1,
    SEND  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Counter width that still works when the terminal count is 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ws2812_pix_if.sv
// Pixel stream between the frame scheduler (master) and the bit-serial driver (slave).
interface ws2812_pix_if;
  import ws2812_pkg::*;

  logic             tx_en;
  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic             pix_ready;
  logic             drv_busy;

  modport master (output tx_en, pix_valid, pix_data, input  pix_ready, drv_busy);
  modport slave  (input  tx_en, pix_valid, pix_data, output pix_ready, drv_busy);

endinterface

// File: rtl/ws2812_rr_arb.sv
// Two-way round-robin arbiter; a tie goes to the source not served last.
module ws2812_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] win
);

  logic last;  // 1: source 1 was served last

  // NOTE: default assignment first so no path through always_comb leaves win unassigned (no latch).
  always_comb begin
    win = req;
    if (req == 2'b11) win = last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk) begin
    if (rst)                    last <= 1'b1;
    else if (update && (|win))  last <= win[1];
  end

endmodule

// File: rtl/ws2812_frame_sched.sv
// Arbitrates two frame sources, streams the latched frame word by word, then holds the strip reset gap.
module ws2812_frame_sched
  import ws2812_pkg::*;
#(
  parameter int N_PIX     = N_PIX_DEF,
  parameter int RESET_CYC = RESET_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req,
  input  logic [N_PIX*PIX_W-1:0] frame0,
  input  logic [N_PIX*PIX_W-1:0] frame1,
  output logic [1:0]             gnt,
  output logic [1:0]             done,
  output logic                   busy,
  ws2812_pix_if.master           pix
);

  localparam int IDX_W = cnt_w(N_PIX);
  localparam int CNT_W = cnt_w(RESET_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PIX - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESET_CYC - 1);

  localparam logic [1:0] ST_GAP   = GAP;
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SEND  = SEND;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  logic [1:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       idx_nxt;
  logic                   owner;
  logic                   post_rst;
  logic [N_PIX*PIX_W-1:0] fbuf;
  logic [N_PIX*PIX_W-1:0] sel_frame;
  logic [1:0]             win;
  logic                   take;

  assign take      = (state == ST_IDLE) && (|req);
  assign sel_frame = win[1] ? frame1 : frame0;
  assign idx_nxt   = idx + 1'b1;

  assign busy      = (state != ST_IDLE);
  assign pix.tx_en = (state == ST_SEND) || (state == ST_DRAIN);

  ws2812_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .update (take),
    .win    (win)
  );

  // NOTE: the frame buffer is plain storage, always loaded before use, so it carries no reset.
  always_ff @(posedge clk) begin
    if (!rst && take) fbuf <= sel_frame;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_GAP;
      cnt           <= '0;
      idx           <= '0;
      owner         <= 1'b0;
      post_rst      <= 1'b1;
      gnt           <= 2'b00;
      done          <= 2'b00;
      pix.pix_valid <= 1'b0;
      pix.pix_data  <= '0;
    end else begin
      gnt  <= 2'b00;
      done <= 2'b00;
      case (state)
        ST_GAP: begin
          if (cnt == CNT_LAST) begin
            state    <= ST_IDLE;
            post_rst <= 1'b0;
            if (!post_rst) done <= owner ? 2'b10 : 2'b01;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (take) begin
            owner         <= win[1];
            gnt           <= win;
            idx           <= '0;
            pix.pix_data  <= sel_frame[PIX_W-1:0];
            pix.pix_valid <= 1'b1;
            state         <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (pix.pix_ready) begin
            if (idx == IDX_LAST) begin
              pix.pix_valid <= 1'b0;
              state         <= ST_DRAIN;
            end else begin
              idx          <= idx_nxt;
              pix.pix_data <= fbuf[PIX_W*int'(idx_nxt) +: PIX_W];
            end
          end
        end
        default: begin  // DRAIN: wait for the driver to finish the last word
          if (!pix.drv_busy) begin
            cnt   <= '0;
            state <= ST_GAP;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_frame_sched.sv
// Directed self-checking bench: a table of frame transactions plus hand-written reset/request corner cases.
module tb_ws2812_frame_sched;
  import ws2812_pkg::*;

  localparam int N = 60;
  localparam int R = 40;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [1:0]         req = 2'b00;
  logic [N*PIX_W-1:0] frame0;
  logic [N*PIX_W-1:0] frame1;
  logic [1:0]         gnt;
  logic [1:0]         done;
  logic               busy;

  ws2812_pix_if pix_bus ();

  ws2812_frame_sched #(.N_PIX(N), .RESET_CYC(R)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .frame0 (frame0),
    .frame1 (frame1),
    .gnt    (gnt),
    .done   (done),
    .busy   (busy),
    .pix    (pix_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic [1:0] exp_gnt;
    int         exp_wait;
    bit         stall;
    int         busy_hold;
  } vec_t;

  vec_t vecs[6];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   gen[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [PIX_W-1:0] pix(input int src, input int g, input int p);
    return {4'(src + 1), 4'(g), 8'(p), 8'(p * 3 + src)};
  endfunction

  task automatic load_frame(input int src);
    for (int p = 0; p < N; p++) begin
      if (src == 0) frame0[PIX_W*p +: PIX_W] = pix(0, gen[0], p);
      else          frame1[PIX_W*p +: PIX_W] = pix(1, gen[1], p);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full frame: grant, stream, drain, gap, done.
  task automatic run_frame(input vec_t v, input string tag);
    logic [PIX_W-1:0] exp_words[N];
    logic [PIX_W-1:0] prev_data;
    int  src, waited, early_done, n_xfer, cyc, unstable, bad, k;
    bit  r, prev_stall;
    src        = v.exp_gnt[1] ? 1 : 0;
    req        = v.req;
    waited     = 0;
    early_done = 0;
    do begin
      tick();
      waited++;
      if (done != 2'b00) early_done++;
    end while (gnt == 2'b00 && waited < R + N + 50);
    check({tag, ".gnt_wait"}, waited, v.exp_wait);
    check({tag, ".gnt"}, gnt, v.exp_gnt);
    check({tag, ".done_quiet"}, early_done, 0);
    check({tag, ".grant_valid"}, {busy, pix_bus.tx_en, pix_bus.pix_valid}, 3'b111);
    for (int p = 0; p < N; p++) exp_words[p] = pix(src, gen[src], p);
    req              = 2'b00;
    pix_bus.drv_busy = 1'b1;
    gen[src]++;
    load_frame(src);

    n_xfer     = 0;
    cyc        = 0;
    unstable   = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    while (pix_bus.pix_valid && cyc < 4 * N) begin
      r = v.stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      pix_bus.pix_ready = r;
      if (prev_stall && pix_bus.pix_data !== prev_data) unstable++;
      if (r) begin
        if (n_xfer < N) check({tag, $sformatf(".word%0d", n_xfer)}, pix_bus.pix_data, exp_words[n_xfer]);
        n_xfer++;
      end
      prev_stall = !r;
      prev_data  = pix_bus.pix_data;
      tick();
      cyc++;
    end
    pix_bus.pix_ready = 1'b0;
    check({tag, ".xfer_count"}, n_xfer, N);
    check({tag, ".stall_stable"}, unstable, 0);
    if (!v.stall) check({tag, ".send_cycles"}, cyc, N);
    check({tag, ".drain_tx_en"}, {busy, pix_bus.tx_en, pix_bus.pix_valid}, 3'b110);

    bad = 0;
    for (int i = 0; i < v.busy_hold; i++) begin
      tick();
      if (!pix_bus.tx_en || done != 2'b00) bad++;
    end
    check({tag, ".drain_hold"}, bad, 0);
    pix_bus.drv_busy = 1'b0;
    tick();
    check({tag, ".gap_tx_en"}, {busy, pix_bus.tx_en}, 2'b10);
    k = 0;
    while (done == 2'b00 && k < R + 20) begin
      tick();
      k++;
    end
    check({tag, ".gap_len"}, k, R);
    check({tag, ".done"}, done, v.exp_gnt);
    check({tag, ".idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t             extra;
    logic [PIX_W-1:0] exp30;
    int               bad;

    vecs[0] = '{req: 2'b01, exp_gnt: 2'b01, exp_wait: R + 1, stall: 1'b0, busy_hold: 0};
    vecs[1] = '{req: 2'b11, exp_gnt: 2'b10, exp_wait: 1,     stall: 1'b1, busy_hold: 0};
    vecs[2] = '{req: 2'b11, exp_gnt: 2'b01, exp_wait: 1,     stall: 1'b0, busy_hold: 100};
    vecs[3] = '{req: 2'b11, exp_gnt: 2'b10, exp_wait: 1,     stall: 1'b1, busy_hold: 3};
    vecs[4] = '{req: 2'b10, exp_gnt: 2'b10, exp_wait: 1,     stall: 1'b0, busy_hold: 0};
    vecs[5] = '{req: 2'b01, exp_gnt: 2'b01, exp_wait: 1,     stall: 1'b1, busy_hold: 0};

    gen[0] = 0;
    gen[1] = 0;
    load_frame(0);
    load_frame(1);
    pix_bus.pix_ready = 1'b0;
    pix_bus.drv_busy  = 1'b0;
    rst = 1'b1;
    req = 2'b01;
    repeat (3) tick();
    check("rst.gnt", gnt, 2'b00);
    check("rst.done", done, 2'b00);
    check("rst.busy", busy, 1'b1);
    check("rst.tx_en", pix_bus.tx_en, 1'b0);
    check("rst.pix_valid", pix_bus.pix_valid, 1'b0);
    check("rst.pix_data", pix_bus.pix_data, 24'h0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("v%0d", i));

    // Reset in the middle of a frame, at pixel 30.
    req = 2'b10;
    tick();
    check("mid.gnt", gnt, 2'b10);
    exp30             = pix(1, gen[1], 30);
    req               = 2'b00;
    pix_bus.pix_ready = 1'b1;
    pix_bus.drv_busy  = 1'b1;
    repeat (30) tick();
    check("mid.pix30", pix_bus.pix_data, exp30);
    rst = 1'b1;
    tick();
    check("mid.rst_outputs", {pix_bus.tx_en, pix_bus.pix_valid, busy, gnt, done}, 7'b0010000);
    check("mid.rst_pix_data", pix_bus.pix_data, 24'h0);
    rst               = 1'b0;
    pix_bus.pix_ready = 1'b0;
    pix_bus.drv_busy  = 1'b0;

    // A request raised during the gap and dropped before IDLE earns no grant.
    bad = 0;
    req = 2'b10;
    repeat (5) begin
      tick();
      if (gnt != 2'b00 || done != 2'b00) bad++;
    end
    req = 2'b00;
    repeat (R + 5) begin
      tick();
      if (gnt != 2'b00 || done != 2'b00) bad++;
    end
    check("mid.no_grant_no_done", bad, 0);
    check("mid.idle_after_gap", busy, 1'b0);

    // First tie after reset goes to source 0, then alternates.
    extra = '{req: 2'b11, exp_gnt: 2'b01, exp_wait: 1, stall: 1'b0, busy_hold: 0};
    run_frame(extra, "post_rst_tie0");
    extra = '{req: 2'b11, exp_gnt: 2'b10, exp_wait: 1, stall: 1'b0, busy_hold: 0};
    run_frame(extra, "post_rst_tie1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
